// File: rtl/stream_frame_packer_if.sv
// ----------------------------------------------------------------------------
// stream_frame_packer_if
// AXI4-Stream style beat bundle shared by the input and output sides of
// stream_frame_packer.
//   tdata  : beat payload, DATA_WIDTH bits
//   tkeep  : byte enables (driven on the master side only)
//   tlast  : end of frame
//   tvalid : beat valid, driven by the master
//   tready : beat accept, driven by the slave
// Modports:
//   master : the side that drives the beats (the packer's output)
//   slave  : the side that receives the beats (the packer's input, tkeep unused)
// ----------------------------------------------------------------------------
interface stream_frame_packer_if #(
    parameter int unsigned DATA_WIDTH = 128
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/stream_frame_packer.sv
// ----------------------------------------------------------------------------
// stream_frame_packer
// Store-and-forward framer: buffers one input frame (up to MAX_BEATS beats),
// then emits a header beat followed by the buffered payload beats.
// Header layout: [15:0] seq (zero-extended), [31:16] beat count, [32] trunc,
// [47:33] zero, [63:48] MAGIC, upper bits zero.
// An input frame longer than MAX_BEATS is cut; the cut piece has trunc=1 and
// the remaining beats start the next output frame.
//
// Ports:
//   clk         : clock
//   resetn      : synchronous active-low reset
//   s           : input stream (slave modport), s.tready registered
//   m           : output stream (master modport), all outputs registered
//   frame_count : number of output frames completed, wraps at 2^32
//
// Build option:
//   STREAM_FRAME_PACKER_CHECKSUM_EN : when defined, a trailer beat holding the
//   XOR of all payload beats follows the payload and carries m.tlast instead.
// ----------------------------------------------------------------------------
module stream_frame_packer #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MAX_BEATS  = 16,
    parameter int unsigned SEQ_WIDTH  = 16,
    parameter logic [15:0] MAGIC      = 16'hE7A5
) (
    input  logic                         clk,
    input  logic                         resetn,
    stream_frame_packer_if.slave         s,
    stream_frame_packer_if.master        m,
    output logic [31:0]                  frame_count
);
    localparam int unsigned AW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    // One extra bit so the count can hold MAX_BEATS itself.
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_BEATS);

`ifdef STREAM_FRAME_PACKER_CHECKSUM_EN
    typedef enum logic [1:0] {StFill, StHdr, StPay, StTrl} state_e;
`else
    typedef enum logic [1:0] {StFill, StHdr, StPay} state_e;
`endif

    state_e                r_state;
    logic [CW-1:0]         r_beat_cnt;
    logic [AW-1:0]         r_rd_ptr;
    logic [SEQ_WIDTH-1:0]  r_seq;
    logic [31:0]           r_frame_count;
    logic                  r_trunc;
    logic                  r_s_tready;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [DATA_WIDTH-1:0] r_buf [MAX_BEATS];
`ifdef STREAM_FRAME_PACKER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_xor;
`endif

    logic                  w_accept;
    logic [CW-1:0]         w_cnt_inc;
    logic                  w_fill_done;
    logic [CW-1:0]         w_last_idx;
    logic                  w_rd_last;
    logic [AW-1:0]         w_rd_next;
    logic                  w_next_is_last;
    logic [DATA_WIDTH-1:0] w_hdr;

    // r_s_tready is only ever high in StFill, so an accept implies StFill.
    assign w_accept       = s.tvalid && r_s_tready;
    assign w_cnt_inc      = r_beat_cnt + CW'(1);
    assign w_fill_done    = w_accept && (s.tlast || (w_cnt_inc == MaxCnt));
    assign w_last_idx     = r_beat_cnt - CW'(1);
    assign w_rd_last      = ({1'b0, r_rd_ptr} == w_last_idx);
    assign w_rd_next      = r_rd_ptr + AW'(1);
    assign w_next_is_last = ({1'b0, w_rd_next} == w_last_idx);

    // Header is built from the count including the beat being accepted; a cut
    // without s.tlast is the only way to leave StFill with trunc set.
    always_comb begin
        w_hdr          = '0;
        w_hdr[15:0]    = 16'(r_seq);
        w_hdr[31:16]   = 16'(w_cnt_inc);
        w_hdr[32]      = !s.tlast;
        w_hdr[63:48]   = MAGIC;
    end

    // Payload buffer, no reset needed: entries are always written before read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_beat_cnt[AW-1:0]] <= s.tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= StFill;
            r_beat_cnt    <= '0;
            r_rd_ptr      <= '0;
            r_seq         <= '0;
            r_frame_count <= '0;
            r_trunc       <= 1'b0;
            r_s_tready    <= 1'b0;
            r_m_tvalid    <= 1'b0;
            r_m_tlast     <= 1'b0;
            r_m_tdata     <= '0;
`ifdef STREAM_FRAME_PACKER_CHECKSUM_EN
            r_xor         <= '0;
`endif
        end else begin
            unique case (r_state)
                StFill: begin
                    r_s_tready <= !w_fill_done;
                    if (w_accept) begin
                        r_beat_cnt <= w_cnt_inc;
`ifdef STREAM_FRAME_PACKER_CHECKSUM_EN
                        r_xor      <= r_xor ^ s.tdata;
`endif
                    end
                    if (w_fill_done) begin
                        r_state    <= StHdr;
                        r_trunc    <= !s.tlast;
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= w_hdr;
                        r_m_tlast  <= 1'b0;
                    end
                end
                StHdr: begin
                    if (m.tready) begin
                        r_state   <= StPay;
                        r_rd_ptr  <= '0;
                        r_m_tdata <= r_buf[0];
`ifdef STREAM_FRAME_PACKER_CHECKSUM_EN
                        r_m_tlast <= 1'b0;
`else
                        r_m_tlast <= (r_beat_cnt == CW'(1));
`endif
                    end
                end
                StPay: begin
                    if (m.tready) begin
                        if (w_rd_last) begin
`ifdef STREAM_FRAME_PACKER_CHECKSUM_EN
                            r_state   <= StTrl;
                            r_m_tdata <= r_xor;
                            r_m_tlast <= 1'b1;
`else
                            r_state       <= StFill;
                            r_seq         <= r_seq + SEQ_WIDTH'(1);
                            r_frame_count <= r_frame_count + 32'd1;
                            r_beat_cnt    <= '0;
                            r_trunc       <= 1'b0;
                            r_s_tready    <= 1'b1;
                            r_m_tvalid    <= 1'b0;
                            r_m_tlast     <= 1'b0;
                            r_m_tdata     <= '0;
`endif
                        end else begin
                            r_rd_ptr  <= w_rd_next;
                            r_m_tdata <= r_buf[w_rd_next];
`ifdef STREAM_FRAME_PACKER_CHECKSUM_EN
                            r_m_tlast <= 1'b0;
`else
                            r_m_tlast <= w_next_is_last;
`endif
                        end
                    end
                end
`ifdef STREAM_FRAME_PACKER_CHECKSUM_EN
                StTrl: begin
                    if (m.tready) begin
                        r_state       <= StFill;
                        r_seq         <= r_seq + SEQ_WIDTH'(1);
                        r_frame_count <= r_frame_count + 32'd1;
                        r_beat_cnt    <= '0;
                        r_trunc       <= 1'b0;
                        r_s_tready    <= 1'b1;
                        r_m_tvalid    <= 1'b0;
                        r_m_tlast     <= 1'b0;
                        r_m_tdata     <= '0;
                        r_xor         <= '0;
                    end
                end
`endif
                default: begin
                    r_state <= StFill;
                end
            endcase
        end
    end

    assign s.tready    = r_s_tready;
    assign m.tvalid    = r_m_tvalid;
    assign m.tlast     = r_m_tlast;
    assign m.tdata     = r_m_tdata;
    assign m.tkeep     = {(DATA_WIDTH/8){r_m_tvalid}};
    assign frame_count = r_frame_count;

    // Trunc flag is carried in the header; the register mirrors the current frame.
    logic w_unused;
    assign w_unused = r_trunc;
endmodule

// File: tb/tb_stream_frame_packer.sv
// ----------------------------------------------------------------------------
// tb_stream_frame_packer
// Self-checking bench: frames are pushed through a queue-based reference model
// that splits input frames into output frames and builds the expected header,
// payload (and trailer when STREAM_FRAME_PACKER_CHECKSUM_EN is defined) beats.
// A negedge monitor compares every accepted output beat and output stability.
// ----------------------------------------------------------------------------
module tb_stream_frame_packer;
    localparam int unsigned DW = 128;
    localparam int unsigned MB = 4;
    localparam int unsigned SW = 2;

    typedef logic [DW-1:0] data_t;
    typedef data_t dq_t[$];
    typedef struct {
        data_t d;
        logic  l;
    } beat_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m_rdy = 1'b1;
    logic [31:0] frame_count;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t exp_q[$];
    int    m_seq    = 0;
    int    m_frames = 0;
    bit    mon_en   = 1'b0;
    bit    stall    = 1'b0;

    data_t p_d;
    logic  p_v = 1'b0;
    logic  p_r = 1'b0;
    logic  p_l = 1'b0;

    stream_frame_packer_if #(.DATA_WIDTH(DW)) s_if ();
    stream_frame_packer_if #(.DATA_WIDTH(DW)) m_if ();

    assign m_if.tready = m_rdy;

    stream_frame_packer #(
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB),
        .SEQ_WIDTH  (SW),
        .MAGIC      (16'hE7A5)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .s           (s_if),
        .m           (m_if),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input data_t got, input data_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic data_t rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected output frame for one buffered chunk of beats.
    task automatic model_emit(input dq_t d, input bit trunc);
        data_t hdr = '0;
        data_t x   = '0;
        hdr[15:0]  = 16'(m_seq);
        hdr[31:16] = 16'(d.size());
        hdr[32]    = trunc;
        hdr[63:48] = 16'hE7A5;
        exp_q.push_back('{hdr, 1'b0});
        foreach (d[i]) begin
            x ^= d[i];
`ifdef STREAM_FRAME_PACKER_CHECKSUM_EN
            exp_q.push_back('{d[i], 1'b0});
`else
            exp_q.push_back('{d[i], (i == d.size() - 1)});
`endif
        end
`ifdef STREAM_FRAME_PACKER_CHECKSUM_EN
        exp_q.push_back('{x, 1'b1});
`endif
        m_seq = (m_seq + 1) % (1 << SW);
        m_frames++;
    endtask

    // Every input frame ends with tlast; chunks of MB beats without it are cut.
    task automatic model_frame(input dq_t d);
        dq_t cur;
        foreach (d[i]) begin
            cur.push_back(d[i]);
            if (i == d.size() - 1) begin
                model_emit(cur, 1'b0);
                cur.delete();
            end else if (cur.size() == MB) begin
                model_emit(cur, 1'b1);
                cur.delete();
            end
        end
    endtask

    // Called just after a posedge; returns just after the posedge of the last accept.
    task automatic send_frame(input dq_t d, input bit gaps, input bit use_model);
        if (use_model) model_frame(d);
        foreach (d[i]) begin
            int waited = 0;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = d[i];
            s_if.tlast  = (i == d.size() - 1);
            @(negedge clk);
            while (!s_if.tready && waited < 200) begin
                waited++;
                @(negedge clk);
            end
            check_eq("s_tready_accept", data_t'(s_if.tready), data_t'(1));
            @(posedge clk);
            #1;
            s_if.tvalid = 1'b0;
            s_if.tlast  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", data_t'(exp_q.size()), data_t'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_frame_count", data_t'(frame_count), data_t'(0));
        check_eq("rst_s_tready", data_t'(s_if.tready), data_t'(0));
        @(posedge clk);
        #1;
        resetn   = 1'b1;
        m_seq    = 0;
        m_frames = 0;
        exp_q.delete();
        mon_en   = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        m_rdy <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (mon_en && resetn) begin
            check_eq("tkeep", data_t'(m_if.tkeep), data_t'({(DW/8){m_if.tvalid}}));
            if (m_if.tvalid) begin
                check_eq("s_tready_blocked", data_t'(s_if.tready), data_t'(0));
            end
            if (p_v && !p_r) begin
                check_eq("hold_valid", data_t'(m_if.tvalid), data_t'(1));
                check_eq("hold_data", m_if.tdata, p_d);
                check_eq("hold_last", data_t'(m_if.tlast), data_t'(p_l));
            end
            if (m_if.tvalid && m_if.tready) begin
                check_eq("beat_expected", data_t'(exp_q.size() != 0), data_t'(1));
                if (exp_q.size() != 0) begin
                    check_eq("beat_data", m_if.tdata, exp_q[0].d);
                    check_eq("beat_last", data_t'(m_if.tlast), data_t'(exp_q[0].l));
                    void'(exp_q.pop_front());
                end
            end
            p_v <= m_if.tvalid;
            p_r <= m_if.tready;
            p_d <= m_if.tdata;
            p_l <= m_if.tlast;
        end else begin
            p_v <= 1'b0;
        end
    end

    initial begin
        dq_t d;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = '1;
        resetn      = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_m_tvalid", data_t'(m_if.tvalid), data_t'(0));
        check_eq("rst_m_tlast", data_t'(m_if.tlast), data_t'(0));
        check_eq("rst_m_tdata", m_if.tdata, data_t'(0));
        check_eq("rst_m_tkeep", data_t'(m_if.tkeep), data_t'(0));
        check_eq("rst_s_tready", data_t'(s_if.tready), data_t'(0));
        check_eq("rst_frame_count", data_t'(frame_count), data_t'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Reset in the middle of a payload: frame is dropped, counters restart.
        d = '{data_t'(128'hB0), data_t'(128'hB1), data_t'(128'hB2)};
        send_frame(d, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("midrst_hdr_valid", data_t'(m_if.tvalid), data_t'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("midrst_in_pay", m_if.tdata, data_t'(128'hB0));
        resetn = 1'b0;
        @(negedge clk);
        check_eq("midrst_tvalid", data_t'(m_if.tvalid), data_t'(0));
        check_eq("midrst_tlast", data_t'(m_if.tlast), data_t'(0));
        check_eq("midrst_frame_count", data_t'(frame_count), data_t'(0));
        @(posedge clk);
        #1;
        resetn   = 1'b1;
        m_seq    = 0;
        m_frames = 0;
        mon_en   = 1'b1;

        // 3-beat frame, no stalls
        d = '{data_t'(128'hA0), data_t'(128'hA1), data_t'(128'hA2)};
        send_frame(d, 1'b0, 1'b1);
        wait_drain();
        check_eq("fc_3beat", data_t'(frame_count), data_t'(m_frames));

        // 6-beat frame forced to split at MB beats
        d.delete();
        for (int i = 0; i < 6; i++) d.push_back(rand_data());
        send_frame(d, 1'b0, 1'b1);
        wait_drain();
        check_eq("fc_split", data_t'(frame_count), data_t'(m_frames));

        // Checksum pattern 1,2,4
        d = '{data_t'(1), data_t'(2), data_t'(4)};
        send_frame(d, 1'b0, 1'b1);
        wait_drain();
        check_eq("fc_xor", data_t'(frame_count), data_t'(m_frames));

        // Five single-beat frames after reset: seq wraps 0,1,2,3,0
        do_reset();
        for (int f = 0; f < 5; f++) begin
            d.delete();
            d.push_back(rand_data());
            send_frame(d, 1'b1, 1'b1);
        end
        wait_drain();
        check_eq("fc_single", data_t'(frame_count), data_t'(5));

        // Random frames under random downstream backpressure
        stall = 1'b1;
        for (int f = 0; f < 12; f++) begin
            int len = $urandom_range(1, 9);
            d.delete();
            for (int i = 0; i < len; i++) d.push_back(rand_data());
            send_frame(d, 1'b1, 1'b1);
        end
        wait_drain();
        check_eq("fc_random", data_t'(frame_count), data_t'(m_frames));
        stall = 1'b0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
